// File: rtl/imem_access_ctrl_if.sv
// Purpose : bundles the fetch, loader and BRAM-port signals of imem_access_ctrl.
// Latency : none; this is wiring only.
// Backpr. : requesters hold req/addr/data until their one-cycle gnt pulse.
//
// Modports:
//   slave  - the controller: takes requests and douta, drives grants and the BRAM port.
//   master - the environment: fetch stage, program loader and the BRAM read data.
// When IMEM_WPROT_EN is defined, wp_lock (in) and load_err (out) are added.
interface imem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    // instruction-fetch requester
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;

    // program-loader requester
    logic              load_req;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [3:0]        load_be;
    logic              load_gnt;

    // BRAM port A
    logic [3:0]        wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic [31:0]       douta;

`ifdef IMEM_WPROT_EN
    logic              wp_lock;
    logic              load_err;

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_req, load_addr, load_data, load_be,
        input  douta, wp_lock,
        output fetch_gnt, fetch_valid, fetch_instr,
        output load_gnt, load_err,
        output wea, addra, dina
    );

    modport master (
        output fetch_req, fetch_addr,
        output load_req, load_addr, load_data, load_be,
        output douta, wp_lock,
        input  fetch_gnt, fetch_valid, fetch_instr,
        input  load_gnt, load_err,
        input  wea, addra, dina
    );
`else
    modport slave (
        input  fetch_req, fetch_addr,
        input  load_req, load_addr, load_data, load_be,
        input  douta,
        output fetch_gnt, fetch_valid, fetch_instr,
        output load_gnt,
        output wea, addra, dina
    );

    modport master (
        output fetch_req, fetch_addr,
        output load_req, load_addr, load_data, load_be,
        output douta,
        input  fetch_gnt, fetch_valid, fetch_instr,
        input  load_gnt,
        input  wea, addra, dina
    );
`endif
endinterface

// File: rtl/imem_access_ctrl.sv
// Purpose : arbitrates one instruction-memory BRAM port between fetch (reads) and loader (writes).
// Latency : grant 1 cycle after winning; fetch data READ_LAT+2 cycles after winning; write done at grant.
// Backpr. : one access in flight; losers hold req until gnt; loader wins unless fetch lost MAX_WAIT times.
//
// Ports:
//   clk, rst_n      - clock (also the BRAM clock) and synchronous active-low reset
//   bus (slave)     - fetch_req/addr -> fetch_gnt/valid/instr,
//                     load_req/addr/data/be -> load_gnt,
//                     BRAM port wea/addra/dina out, douta in
// Optional feature macro IMEM_WPROT_EN: adds bus.wp_lock / bus.load_err write protection.
// All outputs are registered.
module imem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1,    // 1..3
    parameter int MAX_WAIT = 4     // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_access_ctrl_if.slave bus
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lat_q, lat_d;       // cycles spent in RD since addra was driven
    logic [3:0]  wait_q, wait_d;     // consecutive arbitrations fetch has lost

    logic        fetch_win;
    logic        load_win;
    logic        rd_done;
    logic        wp_block;

    // registered outputs and their next values
    logic [3:0]        wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [31:0]       dina_q, dina_d;
    logic              fetch_gnt_q, fetch_gnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [31:0]       fetch_instr_q, fetch_instr_d;
    logic              load_gnt_q, load_gnt_d;

`ifdef IMEM_WPROT_EN
    logic              load_err_q, load_err_d;
    assign wp_block = bus.wp_lock;
`else
    assign wp_block = 1'b0;
`endif

    // douta is valid in the cycle where the RD counter reaches READ_LAT
    assign rd_done = (state_q == S_RD) && (lat_q == LAT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            wait_q  <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, including arbitration and the starvation count
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        wait_d    = wait_q;
        fetch_win = 1'b0;
        load_win  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                lat_d = '0;
                if (bus.fetch_req && (!bus.load_req || (wait_q >= WAIT_MAX))) begin
                    fetch_win = 1'b1;
                    state_d   = S_RD;
                    wait_d    = '0;
                end else if (bus.load_req) begin
                    load_win = 1'b1;
                    state_d  = S_WR;
                    // only a waiting fetch accumulates starvation credit
                    if (bus.fetch_req) begin
                        wait_d = (wait_q < WAIT_MAX) ? wait_q + 4'd1 : WAIT_MAX;
                    end else begin
                        wait_d = '0;
                    end
                end else begin
                    wait_d = '0;
                end
            end

            S_WR: begin
                state_d = S_IDLE;
            end

            S_RD: begin
                if (rd_done) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values for the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        wea_d         = 4'h0;            // write enable only ever lives for the WR cycle
        addra_d       = addra_q;         // address and data hold between accesses
        dina_d        = dina_q;
        fetch_gnt_d   = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        load_gnt_d    = 1'b0;
`ifdef IMEM_WPROT_EN
        load_err_d    = 1'b0;
`endif

        if (load_win) begin
            // a locked write is still granted so the loader does not stall,
            // but it never reaches the memory
            wea_d      = wp_block ? 4'h0 : bus.load_be;
            addra_d    = bus.load_addr;
            dina_d     = bus.load_data;
            load_gnt_d = 1'b1;
`ifdef IMEM_WPROT_EN
            load_err_d = wp_block;
`endif
        end

        if (fetch_win) begin
            addra_d     = bus.fetch_addr;
            fetch_gnt_d = 1'b1;
        end

        if (rd_done) begin
            fetch_valid_d = 1'b1;
            fetch_instr_d = bus.douta;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wea_q         <= 4'h0;
            addra_q       <= '0;
            dina_q        <= '0;
            fetch_gnt_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            load_gnt_q    <= 1'b0;
`ifdef IMEM_WPROT_EN
            load_err_q    <= 1'b0;
`endif
        end else begin
            wea_q         <= wea_d;
            addra_q       <= addra_d;
            dina_q        <= dina_d;
            fetch_gnt_q   <= fetch_gnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            load_gnt_q    <= load_gnt_d;
`ifdef IMEM_WPROT_EN
            load_err_q    <= load_err_d;
`endif
        end
    end

    assign bus.wea         = wea_q;
    assign bus.addra       = addra_q;
    assign bus.dina        = dina_q;
    assign bus.fetch_gnt   = fetch_gnt_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_instr = fetch_instr_q;
    assign bus.load_gnt    = load_gnt_q;
`ifdef IMEM_WPROT_EN
    assign bus.load_err    = load_err_q;
`endif

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequencer/arbiter in front of the InstructionMemory block RAM (ports wea[3:0], addra[31:0], dina[31:0], douta[31:0]).
- Shares the single BRAM port between two requesters: the instruction-fetch stage (reads) and the program loader (byte-enabled word writes).
- Enforces the BRAM read latency, with one access outstanding at a time.
- Loader has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32: width of word addresses on both requester ports and on addra.
- READ_LAT, 1: cycles from addra driven to douta valid (BRAM output latency); legal range 1..3.
- MAX_WAIT, 4: consecutive lost arbitrations after which fetch wins over loader; legal range 1..15.

Ports:
- clk  in  1  system clock; also drives BRAM clka.
- rst_n  in  1  synchronous active-low reset.
- fetch_req  in  1  fetch request; held with fetch_addr until fetch_gnt.
- fetch_addr  in  ADDR_W  word address to read.
- fetch_gnt  out  1  one-cycle pulse: fetch accepted.
- fetch_valid  out  1  one-cycle pulse: fetch_instr valid.
- fetch_instr  out  32  read data, held until next fetch_valid.
- load_req  in  1  write request; held with load_addr/data/be until load_gnt.
- load_addr  in  ADDR_W  word address to write.
- load_data  in  32  write data.
- load_be  in  4  byte enables.
- load_gnt  out  1  one-cycle pulse: write performed.
- wea  out  4  to BRAM write enable.
- addra  out  ADDR_W  to BRAM address.
- dina  out  32  to BRAM write data.
- douta  in  32  from BRAM read data.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low.
- All outputs are registered.
- Reset (rst_n=0 at a rising edge):
  - state IDLE; wea=0, addra=0, dina=0; gnts/valid=0; fetch_instr=0; wait_cnt=0.
  - An in-flight read is dropped; no fetch_valid is ever produced for it.
- States: IDLE, WR, RD.
- Arbitration happens only in IDLE, on the inputs sampled at the edge ending cycle T:
  - Fetch wins if fetch_req=1 and (load_req=0 or wait_cnt==MAX_WAIT).
  - Else loader wins if load_req=1.
  - Else stay IDLE.
- Loader win:
  - Cycle T+1: state WR, wea=load_be, addra=load_addr, dina=load_data, load_gnt=1.
  - Cycle T+2: wea=0, state IDLE, arbitration resumes.
  - load_be=0 is still granted, with wea=0 (no-op write).
- Fetch win:
  - Cycle T+1: state RD, addra=fetch_addr, wea=0, fetch_gnt=1.
  - A cycle counter runs READ_LAT cycles. douta is registered into fetch_instr with fetch_valid=1 at T+2+READ_LAT (T+3 by default); state returns to IDLE in that same cycle.
  - Back-to-back fetch throughput is therefore one read per READ_LAT+2 cycles.
- addra holds its last value while IDLE; dina holds too; wea is 0 in every cycle except WR.
- wait_cnt (4 bits):
  - +1 on each IDLE arbitration where fetch_req=1 and the loader wins.
  - Cleared on fetch win, or on any IDLE cycle with fetch_req=0.
  - Saturates at MAX_WAIT.
- Requesters may drop or alter req/addr/data the cycle after their gnt. Dropping req before gnt is legal; no grant results.
- Simultaneous req in IDLE with wait_cnt<MAX_WAIT: the loader wins, and fetch_req must be held.
- Read/write ordering is inherently safe: no write can issue while RD is pending.
- Address wrap is the BRAM's concern; the controller passes addresses unmodified.

Optional Feature:
- Macro IMEM_WPROT_EN.
- Defined:
  - Adds input wp_lock (1 bit) and output load_err (1 bit, reset 0).
  - A loader win while wp_lock=1 (sampled at T) still goes to WR and pulses load_gnt at T+1, but forces wea=0 and pulses load_err=1 at T+1; memory is unchanged.
- Undefined: neither port exists; all writes proceed.

Test Plan:
- Reset then single fetch: BRAM preloaded [5]=0x8C220004; fetch_req=1, fetch_addr=5 at T. Expect fetch_gnt at T+1, addra=5, fetch_valid with fetch_instr=0x8C220004 at T+3; fetch_gnt and fetch_valid high one cycle only.
- Write then read-back: load addr 7, data 0xDEADBEEF, be=4'hF; expect wea=4'hF for exactly one cycle. Then load addr 7, data 0x00000011, be=4'h1, then fetch 7; expect fetch_instr=0xDEADBE11.
- Contention/starvation: load_req and fetch_req held high continuously, MAX_WAIT=4. Expect 4 load_gnt pulses, then fetch_gnt, then loads again.
- Reset mid-read: assert rst_n=0 the cycle after fetch_gnt. Expect no fetch_valid afterward, and all outputs 0 the cycle after the reset edge.
- Back-to-back fetches to addr 0,1,2 with READ_LAT=2. Expect fetch_valid spaced exactly 4 cycles apart, with correct data order.
- IMEM_WPROT_EN: wp_lock=1, load addr 3, data 0x12345678. Expect load_gnt=1, load_err=1, wea=0; a later fetch of addr 3 returns the original contents.
